// File: rtl/calc_pkg.sv
// Shared types and helpers for the keypad scanner, operand entry and arithmetic unit.
package calc_pkg;

  localparam int MAX_MAG_DEFAULT = 32767;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_NEG  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100
  } op_t;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} entry_state_t;

  typedef enum logic [1:0] {HS_IDLE, HS_ACK, HS_WAIT_LOW} hs_state_t;

  // Sign-magnitude operand as it is being typed.
  typedef struct packed {
    logic        neg;
    logic [14:0] mag;
  } sm_t;

  // Convert a two's-complement value (optionally negated) into sign-magnitude;
  // magnitudes beyond 15 bits saturate so -32768 becomes neg=1, mag=32767.
  function automatic sm_t load_value(input logic [15:0] value, input logic negate);
    logic [16:0] v;
    logic [16:0] a;
    sm_t         r;
    v     = negate ? (17'd0 - {value[15], value}) : {value[15], value};
    a     = v[16] ? (17'd0 - v) : v;
    r.neg = v[16];
    r.mag = (a > 17'd32767) ? 15'h7fff : a[14:0];
    return r;
  endfunction

  // A negative zero magnitude naturally yields 0 here.
  function automatic logic [15:0] to_twos(input sm_t x);
    return x.neg ? (16'd0 - {1'b0, x.mag}) : {1'b0, x.mag};
  endfunction

endpackage

// File: rtl/key_handshake_rx.sv
// Receiving side of the keypad handshake: acknowledges one event per key press.
module key_handshake_rx
  import calc_pkg::*;
(
  input  logic clk,
  input  logic RST,
  input  logic read_input,
  input  logic busy,
  output logic key_read,
  output logic event_accept
);

  hs_state_t r_state;
  hs_state_t w_state_n;

  // Reset lands in HS_WAIT_LOW so a key held through reset is never consumed.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= HS_WAIT_LOW;
    else     r_state <= w_state_n;
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_n    = r_state;
    event_accept = 1'b0;
    case (r_state)
      HS_IDLE: begin
        if (read_input && !busy) begin
          w_state_n    = HS_ACK;
          event_accept = 1'b1;
        end
      end
      HS_ACK:      w_state_n = HS_WAIT_LOW;
      HS_WAIT_LOW: if (!read_input) w_state_n = HS_IDLE;
      default:     w_state_n = HS_WAIT_LOW;
    endcase
  end

  assign key_read = (r_state == HS_ACK);

endmodule

// File: rtl/operand_entry.sv
// Operand entry: builds two signed operands from key events, requests a calculation
// on '=', and holds the result for display or chaining.
module operand_entry
  import calc_pkg::*;
#(
  parameter int MAX_MAG = MAX_MAG_DEFAULT
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        read_input,
  input  logic [3:0]  keypad_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        key_read,
  output logic [15:0] operand_a,
  output logic [15:0] operand_b,
  output logic [2:0]  op_code,
  output logic        calc_valid,
  input  logic        calc_ready,
  input  logic [15:0] result_in,
  output logic [15:0] display_value,
  output logic        entry_err
);

  entry_state_t r_state, w_state_n;
  sm_t          r_a, w_a_n;
  sm_t          r_b, w_b_n;
  logic         r_b_started, w_b_started_n;
  op_t          r_op, w_op_n;
  logic [15:0]  r_result, w_result_n;
  logic         r_err, w_err_n;

  logic         w_accept;
  logic         w_busy;
  op_t          w_key_op;
  logic         w_is_arith;
  logic [18:0]  w_append;
  sm_t          w_from_result;

  assign w_busy = (r_state == CALC);

  key_handshake_rx u_hs (
    .clk          (clk),
    .RST          (RST),
    .read_input   (read_input),
    .busy         (w_busy),
    .key_read     (key_read),
    .event_accept (w_accept)
  );

  assign w_key_op      = op_t'(operator_input);
  assign w_is_arith    = (w_key_op == OP_ADD) || (w_key_op == OP_SUB) || (w_key_op == OP_MUL);
  assign w_append      = 19'((r_state == ENTER_B) ? r_b.mag : r_a.mag) * 19'd10 + 19'(keypad_input);
  assign w_from_result = load_value(r_result, w_key_op == OP_NEG);

  always_comb begin
    w_state_n     = r_state;
    w_a_n         = r_a;
    w_b_n         = r_b;
    w_b_started_n = r_b_started;
    w_op_n        = r_op;
    w_result_n    = r_result;
    w_err_n       = 1'b0;
    if (r_state == CALC) begin
      if (calc_ready) begin
        w_result_n = result_in;
        w_state_n  = SHOW;
      end
    end else if (w_accept) begin
      if (equal_input) begin
        if (r_state == ENTER_B && r_b_started) w_state_n = CALC;
      end else if (w_key_op != OP_NONE) begin
        case (r_state)
          ENTER_A: begin
            if (w_key_op == OP_NEG) begin
              w_a_n.neg = ~r_a.neg;
            end else if (w_is_arith) begin
              w_op_n        = w_key_op;
              w_b_n         = '0;
              w_b_started_n = 1'b0;
              w_state_n     = ENTER_B;
            end
          end
          ENTER_B: begin
            // Until B has a digit, a new operator is a correction of the last one.
            if (w_key_op == OP_NEG)                 w_b_n.neg = ~r_b.neg;
            else if (w_is_arith && !r_b_started)    w_op_n    = w_key_op;
          end
          default: begin
            if (w_key_op == OP_NEG) begin
              w_a_n     = w_from_result;
              w_state_n = ENTER_A;
            end else if (w_is_arith) begin
              w_a_n         = w_from_result;
              w_op_n        = w_key_op;
              w_b_n         = '0;
              w_b_started_n = 1'b0;
              w_state_n     = ENTER_B;
            end
          end
        endcase
      end else if (keypad_input <= 4'd9) begin
        if (r_state == SHOW) begin
          w_a_n     = '{neg: 1'b0, mag: 15'(keypad_input)};
          w_state_n = ENTER_A;
        end else if (w_append > 19'(MAX_MAG)) begin
          w_err_n = 1'b1;
        end else if (r_state == ENTER_A) begin
          w_a_n.mag = w_append[14:0];
        end else begin
          w_b_n.mag     = w_append[14:0];
          w_b_started_n = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state     <= ENTER_A;
      r_a         <= '0;
      r_b         <= '0;
      r_b_started <= 1'b0;
      r_op        <= OP_NONE;
      r_result    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_a         <= w_a_n;
      r_b         <= w_b_n;
      r_b_started <= w_b_started_n;
      r_op        <= w_op_n;
      r_result    <= w_result_n;
      r_err       <= w_err_n;
    end
  end

  assign operand_a  = to_twos(r_a);
  assign operand_b  = to_twos(r_b);
  assign op_code    = r_op;
  assign calc_valid = (r_state == CALC);
  assign entry_err  = r_err;

  always_comb begin
    case (r_state)
      ENTER_B: display_value = r_b_started ? to_twos(r_b) : to_twos(r_a);
      SHOW:    display_value = r_result;
      default: display_value = to_twos(r_a);
    endcase
  end

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed scenarios plus a randomized key stream
// compared against an integer model of the calculator entry rules.
module tb_operand_entry;

  logic        clk = 1'b0;
  logic        RST;
  logic        read_input;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        key_read;
  logic [15:0] operand_a, operand_b, display_value, result_in;
  logic [2:0]  op_code;
  logic        calc_valid, calc_ready, entry_err;

  int tests = 0;
  int fails = 0;

  operand_entry dut (
    .clk            (clk),
    .RST            (RST),
    .read_input     (read_input),
    .keypad_input   (keypad_input),
    .operator_input (operator_input),
    .equal_input    (equal_input),
    .key_read       (key_read),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .op_code        (op_code),
    .calc_valid     (calc_valid),
    .calc_ready     (calc_ready),
    .result_in      (result_in),
    .display_value  (display_value),
    .entry_err      (entry_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (integer arithmetic) ----------------
  localparam int ST_A = 0, ST_B = 1, ST_CALC = 2, ST_SHOW = 3;
  int m_ma, m_na, m_mb, m_nb, m_bs, m_op, m_st, m_res;

  function automatic logic [15:0] m_val(input int neg, input int mag);
    int v;
    v = neg ? -mag : mag;
    return 16'(v);
  endfunction

  function automatic logic [15:0] m_disp();
    case (m_st)
      ST_B:    return m_bs ? m_val(m_nb, m_mb) : m_val(m_na, m_ma);
      ST_SHOW: return 16'(m_res);
      default: return m_val(m_na, m_ma);
    endcase
  endfunction

  task automatic model_reset();
    m_ma = 0; m_na = 0; m_mb = 0; m_nb = 0; m_bs = 0; m_op = 0; m_st = ST_A; m_res = 0;
  endtask

  task automatic model_load_a(input int v);
    m_na = (v < 0);
    m_ma = (v < 0) ? -v : v;
    if (m_ma > 32767) m_ma = 32767;
  endtask

  task automatic model_key(input bit eq, input int op, input int d, output bit exp_err);
    int nm;
    exp_err = 0;
    if (eq) begin
      if (m_st == ST_B && m_bs) m_st = ST_CALC;
    end else if (op != 0) begin
      if (m_st == ST_A) begin
        if (op == 1) m_na = !m_na;
        else begin m_op = op; m_mb = 0; m_nb = 0; m_bs = 0; m_st = ST_B; end
      end else if (m_st == ST_B) begin
        if (op == 1) m_nb = !m_nb;
        else if (!m_bs) m_op = op;
      end else if (m_st == ST_SHOW) begin
        if (op == 1) begin model_load_a(-m_res); m_st = ST_A; end
        else begin model_load_a(m_res); m_op = op; m_mb = 0; m_nb = 0; m_bs = 0; m_st = ST_B; end
      end
    end else if (d <= 9) begin
      if (m_st == ST_SHOW) begin
        m_ma = d; m_na = 0; m_st = ST_A;
      end else begin
        nm = ((m_st == ST_A) ? m_ma : m_mb) * 10 + d;
        if (nm > 32767) exp_err = 1;
        else if (m_st == ST_A) m_ma = nm;
        else begin m_mb = nm; m_bs = 1; end
      end
    end
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    read_input = 0; equal_input = 0; operator_input = 0; keypad_input = 0; calc_ready = 0;
    RST = 1;
    @(negedge clk);
    RST = 0;
    model_reset();
  endtask

  // Presses one key, returns at the negedge where key_read is high (read_input already dropped).
  task automatic press(input bit eq, input int op, input int d, output bit acc);
    @(negedge clk);
    @(negedge clk);
    equal_input = eq; operator_input = op[2:0]; keypad_input = d[3:0]; read_input = 1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (key_read) acc = 1;
    end
    read_input = 0;
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL key_ack_timeout: key_read=0 after 20 cycles, required 1");
    end
  endtask

  // Lets calc_valid run for lat cycles (counting from the current one), then returns the result.
  task automatic do_calc(input int lat, input int res, output int hi);
    hi = calc_valid ? 1 : 0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (calc_valid) hi++;
    end
    result_in = 16'(res); calc_ready = 1;
    @(negedge clk);
    calc_ready = 0;
    if (calc_valid) hi++;
    m_st = ST_SHOW; m_res = res;
  endtask

  task automatic keys(input int seq[$]);
    bit acc, e;
    foreach (seq[i]) begin
      if (seq[i] == 100)      begin press(1, 0, 0, acc); model_key(1, 0, 0, e); end
      else if (seq[i] >= 10)  begin press(0, seq[i] - 10, 0, acc); model_key(0, seq[i] - 10, 0, e); end
      else                    begin press(0, 0, seq[i], acc); model_key(0, 0, seq[i], e); end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int pulses;
    bit acc, e;
    read_input = 1; keypad_input = 4'd5; equal_input = 0; operator_input = 0;
    calc_ready = 0; result_in = 16'h1234; RST = 1;
    @(negedge clk); @(negedge clk);
    tests++;
    if ({key_read, calc_valid, entry_err, operand_a, operand_b, op_code, display_value} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: kr=%b cv=%b err=%b a=%h b=%h op=%b disp=%h, required all zero",
               key_read, calc_valid, entry_err, operand_a, operand_b, op_code, display_value);
    end
    RST = 0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (key_read) pulses++;
    end
    tests++;
    if (pulses !== 0 || operand_a !== 16'h0) begin
      fails++;
      $display("FAIL reset_held_key: pulses=%0d a=%h, required 0 pulses a=0000", pulses, operand_a);
    end
    read_input = 0;
    press(0, 0, 7, acc); model_key(0, 0, 7, e);
    tests++;
    if (operand_a !== 16'd7 || display_value !== 16'd7) begin
      fails++;
      $display("FAIL reset_then_key: a=%h disp=%h, required 0007", operand_a, display_value);
    end
  endtask

  task automatic test_basic_calc();
    int hi;
    do_reset();
    keys('{1, 2, 11, 12, 3, 100});
    tests++;
    if (operand_a !== 16'hFFF4 || operand_b !== 16'd3 || op_code !== 3'b010 || calc_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_operands: a=%h b=%h op=%b cv=%b, required fff4 0003 010 1",
               operand_a, operand_b, op_code, calc_valid);
    end
    do_calc(4, -9, hi);
    tests++;
    if (hi !== 4) begin
      fails++;
      $display("FAIL basic_calc_valid_len: %0d cycles, required 4", hi);
    end
    tests++;
    if (display_value !== 16'hFFF7 || calc_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: disp=%h cv=%b, required fff7 0", display_value, calc_valid);
    end
  endtask

  task automatic test_overflow();
    bit acc, e;
    do_reset();
    keys('{3, 2, 7, 6});
    tests++;
    if (operand_a !== 16'd3276 || entry_err !== 1'b0) begin
      fails++;
      $display("FAIL ovf_3276: a=%0d err=%b, required 3276 0", operand_a, entry_err);
    end
    press(0, 0, 8, acc); model_key(0, 0, 8, e);
    tests++;
    if (entry_err !== 1'b1 || operand_a !== 16'd3276) begin
      fails++;
      $display("FAIL ovf_reject: err=%b a=%0d, required 1 3276", entry_err, operand_a);
    end
    @(negedge clk);
    tests++;
    if (entry_err !== 1'b0) begin
      fails++;
      $display("FAIL ovf_err_pulse: err=%b one cycle later, required 0", entry_err);
    end
    press(0, 0, 7, acc); model_key(0, 0, 7, e);
    press(0, 1, 0, acc); model_key(0, 1, 0, e);
    tests++;
    if (operand_a !== 16'h8001 || entry_err !== 1'b0) begin
      fails++;
      $display("FAIL ovf_max_neg: a=%h err=%b, required 8001 0", operand_a, entry_err);
    end
  endtask

  task automatic test_op_replace();
    int cv;
    do_reset();
    keys('{5, 12, 13});
    tests++;
    if (op_code !== 3'b011 || display_value !== 16'd5) begin
      fails++;
      $display("FAIL replace_op: op=%b disp=%h, required 011 0005", op_code, display_value);
    end
    keys('{100});
    cv = 0;
    for (int i = 0; i < 4; i++) begin
      if (calc_valid) cv++;
      @(negedge clk);
    end
    tests++;
    if (cv !== 0) begin
      fails++;
      $display("FAIL equal_without_b: calc_valid high %0d cycles, required 0", cv);
    end
    keys('{4});
    tests++;
    if (display_value !== 16'd4 || operand_b !== 16'd4) begin
      fails++;
      $display("FAIL b_after_replace: disp=%h b=%h, required 0004", display_value, operand_b);
    end
  endtask

  task automatic test_chain();
    int hi;
    do_reset();
    keys('{9, 12, 3, 6, 100});
    do_calc(2, 45, hi);
    keys('{14, 2, 100});
    tests++;
    if (operand_a !== 16'd45 || operand_b !== 16'd2 || op_code !== 3'b100 || calc_valid !== 1'b1) begin
      fails++;
      $display("FAIL chain_mul: a=%0d b=%0d op=%b cv=%b, required 45 2 100 1",
               operand_a, operand_b, op_code, calc_valid);
    end
    do_calc(1, -32768, hi);
    keys('{12});
    tests++;
    if (operand_a !== 16'h8001 || op_code !== 3'b010) begin
      fails++;
      $display("FAIL chain_clamp: a=%h op=%b, required 8001 010", operand_a, op_code);
    end
  endtask

  task automatic test_equal_priority();
    bit acc, e;
    int hi;
    do_reset();
    keys('{4, 12, 7});
    press(1, 2, 0, acc); model_key(1, 2, 0, e);
    tests++;
    if (calc_valid !== 1'b1 || op_code !== 3'b010) begin
      fails++;
      $display("FAIL equal_priority: cv=%b op=%b, required 1 010", calc_valid, op_code);
    end
    do_calc(1, 11, hi);
  endtask

  task automatic test_backpressure();
    int pulses;
    bit e;
    do_reset();
    keys('{1, 12, 2, 100});
    @(negedge clk); @(negedge clk);
    equal_input = 0; operator_input = 0; keypad_input = 4'd5; read_input = 1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (key_read) pulses++;
    end
    result_in = 16'd3; calc_ready = 1;
    @(negedge clk);
    calc_ready = 0;
    if (key_read) pulses++;
    m_st = ST_SHOW; m_res = 3;
    tests++;
    if (pulses !== 0 || display_value !== 16'd3) begin
      fails++;
      $display("FAIL backpressure: pulses=%0d disp=%h, required 0 0003", pulses, display_value);
    end
    @(negedge clk);
    model_key(0, 0, 5, e);
    tests++;
    if (key_read !== 1'b1 || operand_a !== 16'd5) begin
      fails++;
      $display("FAIL key_after_show: kr=%b a=%h, required 1 0005", key_read, operand_a);
    end
    @(negedge clk);
    read_input = 0;
    tests++;
    if (key_read !== 1'b0) begin
      fails++;
      $display("FAIL key_read_single: kr=%b second cycle, required 0", key_read);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    keys('{2, 12, 3, 100});
    #2 RST = 1;
    #1;
    tests++;
    if (key_read !== 1'b0 || calc_valid !== 1'b0 || operand_a !== 16'h0 || op_code !== 3'b000) begin
      fails++;
      $display("FAIL async_reset: kr=%b cv=%b a=%h op=%b, required 0 0 0000 000",
               key_read, calc_valid, operand_a, op_code);
    end
    @(negedge clk);
    RST = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit acc, e;
    int kind, op, d, hi, lat, res;
    logic [52:0] exp_v, got_v;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      if (m_st != ST_CALC && $urandom_range(0, 7) == 0) begin
        @(negedge clk);
        result_in = 16'($urandom); calc_ready = 1;
        @(negedge clk);
        calc_ready = 0;
      end
      kind = $urandom_range(0, 9);
      op = 0; d = 0;
      if (kind < 2)      begin end
      else if (kind < 5) op = $urandom_range(1, 4);
      else               d = $urandom_range(0, 11);
      press(kind < 2, op, d, acc);
      model_key(kind < 2, op, d, e);
      exp_v = {m_val(m_na, m_ma), m_val(m_nb, m_mb), 3'(m_op), m_disp(), m_st == ST_CALC, e};
      got_v = {operand_a, operand_b, op_code, display_value, calc_valid, entry_err};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL rand_key[%0d]: a/b/op/disp/cv/err got %h %h %b %h %b %b required %h %h %b %h %b %b",
                 n, got_v[52:37], got_v[36:21], got_v[20:18], got_v[17:2], got_v[1], got_v[0],
                 exp_v[52:37], exp_v[36:21], exp_v[20:18], exp_v[17:2], exp_v[1], exp_v[0]);
      end
      if (m_st == ST_CALC) begin
        lat = $urandom_range(1, 5);
        res = ($urandom_range(0, 9) == 0) ? -32768 : int'($urandom_range(0, 4000)) - 2000;
        do_calc(lat, res, hi);
        tests++;
        if (hi !== lat || display_value !== 16'(res)) begin
          fails++;
          $display("FAIL rand_calc[%0d]: cv_cycles=%0d disp=%h required %0d %h",
                   n, hi, display_value, lat, 16'(res));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_calc();
    test_overflow();
    test_op_replace();
    test_chain();
    test_equal_priority();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
